serial_adder: RTL and testbench

//  Multi-cycle, digit-serial two's-complement adder/subtractor for WIDTH-bit operands.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/serial_adder_add_slice.sv | 30 +++
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// Provides the FSM state enum, the step-count function and a counter-width helper.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of digit steps needed to cover one operand.
   function automatic int nsteps(input int width, input int digit);
      return width / digit;
   endfunction

   // Counter width for n states; at least one bit so the
   // single-step configuration still has a legal vector.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_adder_add_slice.sv
// Combinational DIGIT-bit ripple-carry slice built from 1-bit full adders.
// Ports: a, b (DIGIT) operands; cin carry in; s (DIGIT) sum; cout carry out; cmsb carry into MSB.
module add_slice
   import adder_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   logic [DIGIT:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i])
                      | ((a[i] ^ b[i]) & w_c[i]);
   end

   assign cout = w_c[DIGIT];
   // Carry entering the top cell; xor with cout gives signed overflow.
   assign cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder/subtractor, DIGIT bits per cycle, LSB first.
// Ports: Clk, Reset; InValid/InReady + OpA, OpB, CarryIn, Sub; OutValid/OutReady + Sum, CarryOut, Overflow.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic             CarryIn,
   input  logic             Sub,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Sum,
   output logic             CarryOut,
   output logic             Overflow
);

   localparam int NSTEPS = nsteps(WIDTH, DIGIT);
   localparam int CW     = cnt_w(NSTEPS);
   localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

   if (DIGIT < 1 || DIGIT > WIDTH
       || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder: DIGIT must divide WIDTH");
   end

   state_e           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_cout;
   logic             r_ovf;

   logic [DIGIT-1:0] w_s;
   logic             w_cout;
   logic             w_cmsb;
   logic [WIDTH-1:0] w_sum_nxt;

   add_slice #(
      .DIGIT (DIGIT)
   ) u_slice (
      .a    (r_a[DIGIT-1:0]),
      .b    (r_b[DIGIT-1:0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout),
      .cmsb (w_cmsb)
   );

   // New digit enters at the MSB end, so after NSTEPS
   // shifts the first digit has reached bit 0.
   if (DIGIT == WIDTH) begin : g_sum_full
      assign w_sum_nxt = w_s;
   end else begin : g_sum_shift
      assign w_sum_nxt = {w_s, r_sum[WIDTH-1:DIGIT]};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (InValid) begin
                  r_a        <= OpA;
                  // Subtract as A + ~B + 1.
                  r_b        <= Sub ? ~OpB : OpB;
                  r_carry    <= Sub ? 1'b1 : CarryIn;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_sum   <= w_sum_nxt;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_cout      <= w_cout;
                  r_ovf       <= w_cmsb ^ w_cout;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (OutReady) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign InReady  = r_in_ready;
   assign OutValid = r_out_valid;
   assign Sum      = r_sum;
   assign CarryOut = r_cout;
   assign Overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder in three configurations.
// Index 0: WIDTH16/DIGIT4, 1: WIDTH8/DIGIT1, 2: WIDTH16/DIGIT16.
module tb_serial_adder;

   logic        clk;
   logic        rst;
   logic [15:0] opa;
   logic [15:0] opb;
   logic        ci;
   logic        sb;
   logic [2:0]  iv;
   logic [2:0]  ordy;
   wire  [2:0]  irdy;
   wire  [2:0]  ov;
   wire  [2:0]  co;
   wire  [2:0]  of;
   wire  [15:0] sum_m;
   wire  [7:0]  sum_8;
   wire  [15:0] sum_f;

   int n_tests = 0;
   int n_fail  = 0;

   serial_adder #(.WIDTH(16), .DIGIT(4)) dut_m (
      .Clk(clk), .Reset(rst),
      .InValid(iv[0]), .InReady(irdy[0]),
      .OpA(opa), .OpB(opb),
      .CarryIn(ci), .Sub(sb),
      .OutValid(ov[0]), .OutReady(ordy[0]),
      .Sum(sum_m), .CarryOut(co[0]), .Overflow(of[0])
   );

   serial_adder #(.WIDTH(8), .DIGIT(1)) dut_8 (
      .Clk(clk), .Reset(rst),
      .InValid(iv[1]), .InReady(irdy[1]),
      .OpA(opa[7:0]), .OpB(opb[7:0]),
      .CarryIn(ci), .Sub(sb),
      .OutValid(ov[1]), .OutReady(ordy[1]),
      .Sum(sum_8), .CarryOut(co[1]), .Overflow(of[1])
   );

   serial_adder #(.WIDTH(16), .DIGIT(16)) dut_f (
      .Clk(clk), .Reset(rst),
      .InValid(iv[2]), .InReady(irdy[2]),
      .OpA(opa), .OpB(opb),
      .CarryIn(ci), .Sub(sb),
      .OutValid(ov[2]), .OutReady(ordy[2]),
      .Sum(sum_f), .CarryOut(co[2]), .Overflow(of[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] get_sum(input int k);
      case (k)
         0:       return sum_m;
         1:       return {8'h00, sum_8};
         default: return sum_f;
      endcase
   endfunction

   function automatic int steps_of(input int k);
      case (k)
         0:       return 4;
         1:       return 8;
         default: return 1;
      endcase
   endfunction

   // Present an op at the current negedge and wait for acceptance.
   // Returns at the first negedge after the capture edge.
   task automatic send(input int k, input logic [15:0] a,
                       input logic [15:0] b, input logic c,
                       input logic s, output bit ok);
      ok = 0;
      opa = a; opb = b; ci = c; sb = s;
      iv[k] = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (irdy[k]) ok = 1;
         @(negedge clk);
      end
      iv[k] = 1'b0;
   endtask

   // Wait for OutValid; lat = capture-to-valid edge count.
   task automatic wait_valid(input int k, input bit rnd,
                             output int lat, output bit ok);
      lat = 0;
      while (!ov[k] && lat < 100) begin
         if (rnd) ordy[k] = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      ordy[k] = 1'b0;
      ok = ov[k];
   endtask

   task automatic accept(input int k);
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (irdy !== 3'b111) begin
         n_fail++;
         $display("FAIL reset_inready got=%b exp=111", irdy);
      end
      n_tests++;
      if (ov !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outvalid got=%b exp=000", ov);
      end
      n_tests++;
      if ({sum_m, sum_8, sum_f} !== 40'h0) begin
         n_fail++;
         $display("FAIL reset_sum got=%h/%h/%h exp=0",
                  sum_m, sum_8, sum_f);
      end
      n_tests++;
      if ({co, of} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags co=%b of=%b exp=0", co, of);
      end
   endtask

   // Table: a, b, ci, sub, sum, co, of
   task automatic run_table(input string nm,
                            input logic [15:0] ta[],
                            input logic [15:0] tb[],
                            input logic [1:0]  tcs[],
                            input logic [17:0] texp[]);
      bit ok;
      int lat;
      for (int i = 0; i < ta.size(); i++) begin
         send(0, ta[i], tb[i], tcs[i][1], tcs[i][0], ok);
         wait_valid(0, 0, lat, ok);
         n_tests++;
         if (!ok || lat != 4) begin
            n_fail++;
            $display("FAIL %s_latency[%0d] got=%0d exp=4",
                     nm, i, lat);
         end
         n_tests++;
         if ({sum_m, co[0], of[0]} !== texp[i]) begin
            n_fail++;
            $display("FAIL %s_result[%0d] got=%h/%b/%b exp=%h/%b/%b",
                     nm, i, sum_m, co[0], of[0],
                     texp[i][17:2], texp[i][1], texp[i][0]);
         end
         accept(0);
         n_tests++;
         if (irdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release[%0d] got rdy=%b v=%b exp 1/0",
                     nm, i, irdy[0], ov[0]);
         end
      end
   endtask

   task automatic test_add();
      run_table("add",
         '{16'hFFFF, 16'h7FFF, 16'h1234},
         '{16'h0001, 16'h0001, 16'h4321},
         '{2'b00,    2'b00,    2'b10},
         '{{16'h0000, 2'b10},
           {16'h8000, 2'b01},
           {16'h5556, 2'b00}});
   endtask

   task automatic test_sub();
      run_table("sub",
         '{16'h0005, 16'h8000},
         '{16'h0007, 16'h0001},
         '{2'b11,    2'b01},
         '{{16'hFFFE, 2'b00},
           {16'h7FFF, 2'b11}});
   endtask

   task automatic test_stall();
      bit ok;
      int lat;
      send(0, 16'h0100, 16'h0200, 1'b0, 1'b0, ok);
      wait_valid(0, 0, lat, ok);
      for (int i = 0; i < 10; i++) begin
         opa = 16'($urandom); opb = 16'($urandom);
         sb = 1'($urandom); ci = 1'($urandom);
         iv[0] = 1'b1;
         @(negedge clk);
         n_tests++;
         if ({ov[0], irdy[0], sum_m, co[0], of[0]}
             !== {2'b10, 16'h0300, 2'b00}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d] v=%b r=%b s=%h c=%b o=%b exp 1/0/0300/0/0",
                     i, ov[0], irdy[0], sum_m, co[0], of[0]);
         end
      end
      iv[0] = 1'b0;
      accept(0);
      n_tests++;
      if (irdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release got rdy=%b v=%b exp 1/0",
                  irdy[0], ov[0]);
      end
      repeat (2) @(negedge clk);
      n_tests++;
      if (irdy[0] !== 1'b1 || ov[0] !== 1'b0
          || sum_m !== 16'h0300) begin
         n_fail++;
         $display("FAIL stall_noqueue rdy=%b v=%b s=%h exp 1/0/0300",
                  irdy[0], ov[0], sum_m);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int lat;
      send(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, ok);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({ov[0], irdy[0], sum_m, co[0], of[0]}
          !== {2'b01, 16'h0000, 2'b00}) begin
         n_fail++;
         $display("FAIL abort_state v=%b r=%b s=%h c=%b o=%b exp 0/1/0000/0/0",
                  ov[0], irdy[0], sum_m, co[0], of[0]);
      end
      send(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, ok);
      wait_valid(0, 0, lat, ok);
      n_tests++;
      if (!ok || {sum_m, co[0], of[0]} !== {16'h0100, 2'b00}) begin
         n_fail++;
         $display("FAIL abort_next got=%h/%b/%b exp=0100/0/0",
                  sum_m, co[0], of[0]);
      end
      accept(0);
   endtask

   task automatic test_back_to_back(input int k, input int w,
                                    input int nops);
      bit ok;
      int lat;
      logic [15:0] mask, a, b, bb, es;
      logic [16:0] full;
      logic c, s, ec, eo;
      mask = (w == 16) ? 16'hFFFF : 16'h00FF;
      for (int i = 0; i < nops; i++) begin
         a = 16'($urandom) & mask;
         b = 16'($urandom) & mask;
         if (i == 0) a = mask;
         if (i == 1) b = 16'h0;
         c = 1'($urandom);
         s = 1'($urandom);
         bb = s ? (~b & mask) : b;
         full = {1'b0, a} + {1'b0, bb} + {16'h0, (s | c)};
         es = full[15:0] & mask;
         ec = full[w];
         eo = (a[w-1] == bb[w-1]) && (es[w-1] != a[w-1]);
         send(k, a, b, c, s, ok);
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL b2b%0d_accept[%0d] timed out", k, i);
         end
         wait_valid(k, 1, lat, ok);
         n_tests++;
         if (!ok || lat != steps_of(k)) begin
            n_fail++;
            $display("FAIL b2b%0d_latency[%0d] got=%0d exp=%0d",
                     k, i, lat, steps_of(k));
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         n_tests++;
         if ({get_sum(k), co[k], of[k]} !== {es, ec, eo}) begin
            n_fail++;
            $display("FAIL b2b%0d_result[%0d] a=%h b=%h c=%b s=%b got=%h/%b/%b exp=%h/%b/%b",
                     k, i, a, b, c, s, get_sum(k), co[k], of[k],
                     es, ec, eo);
         end
         accept(k);
      end
   endtask

   initial begin
      rst = 1'b1;
      iv = '0; ordy = '0;
      opa = '0; opb = '0; ci = 1'b0; sb = 1'b0;
      @(negedge clk);
      test_reset();
      test_add();
      test_sub();
      test_stall();
      test_reset_mid();
      test_back_to_back(1, 8, 30);
      test_back_to_back(0, 16, 30);
      test_back_to_back(2, 16, 30);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
